// File: rtl/lockpick_pkg.sv
// lockpick_pkg: shared constants and types for the lockpick result framer.
// Status codes, default sync byte, frame overhead and framer state encoding.
package lockpick_pkg;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_ERROR   = 2'b01;
    localparam logic [1:0] ST_WIN     = 2'b10;
    localparam logic [1:0] ST_LOCKOUT = 2'b11;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // sync + header + checksum around the payload
    localparam int FRAME_OVERHEAD = 3;

    typedef enum logic [2:0] {
        FR_IDLE,
        FR_CAPTURE,
        FR_SEND_SYNC,
        FR_SEND_HDR,
        FR_SEND_PAYLOAD,
        FR_SEND_CHK
    } framer_state_e;

    // Header: low nibble of the frame counter, two zero bits, game status.
    function automatic logic [7:0] make_header(
        input logic [3:0] count_lo,
        input logic [1:0] status
    );
        return {count_lo, 2'b00, status};
    endfunction

endpackage

// File: rtl/lockpick_chk_accum.sv
// lockpick_chk_accum: running frame checksum over header and payload bytes.
// XOR by default; CRC-8 (poly 0x07, init 0, MSB-first) with LOCKPICK_FRAMER_CRC_EN.
module lockpick_chk_accum
    import lockpick_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       en,
    input  logic [7:0] data,
    output logic [7:0] chk
);

`ifdef LOCKPICK_FRAMER_CRC_EN
    function automatic logic [7:0] chk_step(
        input logic [7:0] acc,
        input logic [7:0] d
    );
        logic [7:0] c;
        c = acc ^ d;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction
`else
    function automatic logic [7:0] chk_step(
        input logic [7:0] acc,
        input logic [7:0] d
    );
        return acc ^ d;
    endfunction
`endif

    // Accumulator: cleared at frame start, folds in one byte per enable.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            chk <= '0;
        end else if (en) begin
            chk <= chk_step(chk, data);
        end
    end

endmodule

// File: rtl/lockpick_result_framer.sv
// lockpick_result_framer: wraps the game core's result bytes into a framed stream.
// Frame: SYNC, header, payload, checksum; LOCKPICK_FRAMER_CRC_EN selects CRC-8 checksum.
module lockpick_result_framer
    import lockpick_pkg::*;
#(
    parameter int         PAYLOAD_BYTES = 16,
    parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEFAULT
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic [1:0] in_status,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    input  logic       tx_ready,
    output logic       frame_busy,
    output logic       overflow,
    output logic [7:0] frame_count
);

    // PAYLOAD_BYTES is expected in 2..32; cnt must reach PAYLOAD_BYTES.
    localparam int CW = $clog2(PAYLOAD_BYTES + 1);
    localparam int IW = $clog2(PAYLOAD_BYTES);
    localparam logic [CW-1:0] LAST_IDX   = CW'(PAYLOAD_BYTES - 1);
    localparam logic [CW-1:0] ALL_LOADED = CW'(PAYLOAD_BYTES);

    framer_state_e state;
    logic [CW-1:0] cnt;
    logic [7:0]    payload [PAYLOAD_BYTES];
    logic [1:0]    status_q;

    logic          tx_fire;
    logic [IW-1:0] sel;
    logic [7:0]    sel_byte;
    logic [7:0]    hdr_byte;
    logic [7:0]    chk;
    logic          acc_clear;
    logic          acc_en;
    logic [7:0]    acc_byte;

    assign tx_fire  = tx_valid && tx_ready;
    assign sel      = (cnt < ALL_LOADED) ? cnt[IW-1:0] : '0;
    assign sel_byte = payload[sel];
    assign hdr_byte = make_header(frame_count[3:0], status_q);

    // Feed the checksum as each header/payload byte is loaded into tx_data,
    // so the sum is complete the moment the last payload byte leaves.
    always_comb begin
        acc_clear = 1'b0;
        acc_en    = 1'b0;
        acc_byte  = hdr_byte;
        unique case (state)
            FR_CAPTURE: begin
                acc_clear = in_valid && (cnt == LAST_IDX);
            end
            FR_SEND_SYNC: begin
                acc_en   = tx_fire;
                acc_byte = hdr_byte;
            end
            FR_SEND_HDR: begin
                acc_en   = tx_fire;
                acc_byte = payload[0];
            end
            FR_SEND_PAYLOAD: begin
                acc_en   = tx_fire && (cnt != ALL_LOADED);
                acc_byte = sel_byte;
            end
            default: begin
                acc_en = 1'b0;
            end
        endcase
    end

    lockpick_chk_accum u_chk (
        .clk   (clk),
        .rst   (rst),
        .clear (acc_clear),
        .en    (acc_en),
        .data  (acc_byte),
        .chk   (chk)
    );

    // Frame FSM: capture payload, then stream sync/header/payload/checksum.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FR_IDLE;
            cnt         <= '0;
            status_q    <= ST_IDLE;
            tx_valid    <= 1'b0;
            tx_data     <= '0;
            frame_busy  <= 1'b0;
            overflow    <= 1'b0;
            frame_count <= '0;
            for (int i = 0; i < PAYLOAD_BYTES; i++) begin
                payload[i] <= '0;
            end
        end else begin
            unique case (state)
                FR_IDLE: begin
                    if (in_valid) begin
                        payload[0] <= in_data;
                        cnt        <= CW'(1);
                        state      <= FR_CAPTURE;
                        frame_busy <= 1'b1;
                    end
                end
                FR_CAPTURE: begin
                    if (in_valid) begin
                        payload[cnt[IW-1:0]] <= in_data;
                        if (cnt == LAST_IDX) begin
                            status_q <= in_status;
                            state    <= FR_SEND_SYNC;
                            tx_valid <= 1'b1;
                            tx_data  <= SYNC_BYTE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                FR_SEND_SYNC: begin
                    if (in_valid) begin
                        overflow <= 1'b1;
                    end
                    if (tx_fire) begin
                        tx_data <= hdr_byte;
                        state   <= FR_SEND_HDR;
                    end
                end
                FR_SEND_HDR: begin
                    if (in_valid) begin
                        overflow <= 1'b1;
                    end
                    if (tx_fire) begin
                        tx_data <= payload[0];
                        cnt     <= CW'(1);
                        state   <= FR_SEND_PAYLOAD;
                    end
                end
                FR_SEND_PAYLOAD: begin
                    if (in_valid) begin
                        overflow <= 1'b1;
                    end
                    if (tx_fire) begin
                        if (cnt == ALL_LOADED) begin
                            tx_data <= chk;
                            state   <= FR_SEND_CHK;
                        end else begin
                            tx_data <= sel_byte;
                            cnt     <= cnt + 1'b1;
                        end
                    end
                end
                FR_SEND_CHK: begin
                    if (tx_fire) begin
                        tx_valid    <= 1'b0;
                        frame_count <= frame_count + 1'b1;
                        // A byte arriving with the final transfer opens the next frame.
                        if (in_valid) begin
                            payload[0] <= in_data;
                            cnt        <= CW'(1);
                            state      <= FR_CAPTURE;
                        end else begin
                            cnt        <= '0;
                            state      <= FR_IDLE;
                            frame_busy <= 1'b0;
                        end
                    end else if (in_valid) begin
                        overflow <= 1'b1;
                    end
                end
                default: begin
                    state      <= FR_IDLE;
                    tx_valid   <= 1'b0;
                    frame_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lockpick_result_framer.sv
// tb_lockpick_result_framer: table-driven frames with a byte scoreboard,
// plus backpressure, back-to-back, overflow and mid-frame reset sequences.
module tb_lockpick_result_framer;

    localparam int         PB   = 16;
    localparam logic [7:0] SYNC = 8'hA5;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic [1:0] in_status;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       frame_busy;
    logic       overflow;
    logic [7:0] frame_count;

    int checks = 0;
    int errors = 0;
    int exp_count = 0;
    bit rnd_ready = 1'b0;
    logic [7:0] sbq [$];

    typedef struct {
        logic [1:0]      st;
        logic [PB*8-1:0] pl;
        int              gap;
        bit              rnd;
        logic [7:0]      exp_hdr;
    } vec_t;

    vec_t vecs [5];

    always #5 clk = ~clk;

    lockpick_result_framer dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_status   (in_status),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .frame_busy  (frame_busy),
        .overflow    (overflow),
        .frame_count (frame_count)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] crc_bits(input logic [7:0] c,
                                            input logic [7:0] d);
        logic [7:0] r;
        logic fb;
        r = c;
        for (int b = 7; b >= 0; b--) begin
            fb = r[7] ^ d[b];
            r = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return r;
    endfunction

    function automatic logic [7:0] model_chk(input logic [7:0] hdr,
                                             input logic [PB*8-1:0] pl);
        logic [7:0] c;
`ifdef LOCKPICK_FRAMER_CRC_EN
        c = crc_bits(8'h00, hdr);
        for (int i = 0; i < PB; i++) c = crc_bits(c, pl[i*8 +: 8]);
`else
        c = hdr;
        for (int i = 0; i < PB; i++) c = c ^ pl[i*8 +: 8];
`endif
        return c;
    endfunction

    function automatic logic [7:0] hdr_of(input logic [1:0] st);
        logic [31:0] n;
        n = exp_count;
        return {n[3:0], 2'b00, st};
    endfunction

    // Byte monitor: every handshake about to complete is checked in order.
    always @(negedge clk) begin
        if (rst === 1'b0 && tx_valid === 1'b1 && tx_ready === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL tx_unexpected got %02h want none", tx_data);
            end else begin
                check("tx_byte", {24'b0, tx_data}, {24'b0, sbq.pop_front()});
            end
        end
    end

    task automatic drive_frame(input logic [1:0] st, input logic [PB*8-1:0] pl,
                               input int gap, input logic [7:0] hdr);
        in_status = st;
        for (int i = 0; i < PB; i++) begin
            in_valid = 1'b1;
            in_data  = pl[i*8 +: 8];
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (i < PB - 1) repeat (gap) begin @(posedge clk); #1; end
        end
        sbq.push_back(SYNC);
        sbq.push_back(hdr);
        for (int i = 0; i < PB; i++) sbq.push_back(pl[i*8 +: 8]);
        sbq.push_back(model_chk(hdr, pl));
        exp_count++;
        check("sync_lat_valid", tx_valid, 1);
        check("sync_lat_data", tx_data, SYNC);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((sbq.size() != 0 || frame_busy !== 1'b0) && n < 500) begin
            @(posedge clk); #1;
            if (rnd_ready) tx_ready = 1'($urandom_range(0, 1));
            n++;
        end
        tx_ready  = 1'b1;
        rnd_ready = 1'b0;
        if (n >= 500) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout got %0d left want 0", name, sbq.size());
        end
        check({name, "_count"}, frame_count, exp_count % 256);
    endtask

    function automatic logic [PB*8-1:0] pat(input int seed);
        logic [PB*8-1:0] p;
        for (int i = 0; i < PB; i++) p[i*8 +: 8] = 8'($urandom_range(0, 255) ^ seed);
        return p;
    endfunction

    initial begin
        logic [7:0]      h;
        logic [PB*8-1:0] pa;

        for (int i = 0; i < PB; i++) begin
            vecs[0].pl[i*8 +: 8] = (i % 2 == 0) ? 8'hCE : 8'hFA;
            vecs[1].pl[i*8 +: 8] = (i % 2 == 0) ? 8'hD0 : 8'hBA;
            vecs[2].pl[i*8 +: 8] = (i % 2 == 0) ? 8'hD0 : 8'hBA;
            vecs[3].pl[i*8 +: 8] = 8'(i);
            vecs[4].pl[i*8 +: 8] = 8'(i * 17) ^ 8'h3C;
        end
        vecs[0].st = 2'b10; vecs[0].gap = 0; vecs[0].rnd = 0; vecs[0].exp_hdr = 8'h02;
        vecs[1].st = 2'b01; vecs[1].gap = 0; vecs[1].rnd = 0; vecs[1].exp_hdr = 8'h11;
        vecs[2].st = 2'b01; vecs[2].gap = 1; vecs[2].rnd = 0; vecs[2].exp_hdr = 8'h21;
        vecs[3].st = 2'b11; vecs[3].gap = 2; vecs[3].rnd = 1; vecs[3].exp_hdr = 8'h33;
        vecs[4].st = 2'b00; vecs[4].gap = 0; vecs[4].rnd = 1; vecs[4].exp_hdr = 8'h40;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_status = '0; tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_busy", frame_busy, 0);
        check("rst_overflow", overflow, 0);
        check("rst_count", frame_count, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < 5; v++) begin
            rnd_ready = vecs[v].rnd;
            drive_frame(vecs[v].st, vecs[v].pl, vecs[v].gap, vecs[v].exp_hdr);
            wait_idle($sformatf("vec%0d", v));
        end

        // Backpressure while the header is offered.
        tx_ready = 1'b0;
        h = hdr_of(2'b10);
        drive_frame(2'b10, vecs[0].pl, 0, h);
        tx_ready = 1'b1;
        @(posedge clk); #1;
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_valid", tx_valid, 1);
            check("bp_hold", tx_data, h);
        end
        tx_ready = 1'b1;
        wait_idle("bp");

        // Next frame's first byte lands on the checksum transfer.
        h = hdr_of(2'b11);
        drive_frame(2'b11, pat(8'h5A), 0, h);
        repeat (18) begin @(posedge clk); #1; end
        h = hdr_of(2'b01);
        drive_frame(2'b01, pat(8'hC3), 0, h);
        check("b2b_no_overflow", overflow, 0);
        wait_idle("b2b");

        // Stray byte during payload transmission.
        h = hdr_of(2'b10);
        drive_frame(2'b10, pat(8'h11), 0, h);
        repeat (3) begin @(posedge clk); #1; end
        in_valid = 1'b1; in_data = 8'h55;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("ovf_set", overflow, 1);
        wait_idle("ovf");
        h = hdr_of(2'b00);
        drive_frame(2'b00, pat(8'h77), 1, h);
        wait_idle("ovf_clean");
        check("ovf_sticky", overflow, 1);

        // Reset after 8 captured bytes.
        pa = pat(8'h0F);
        in_status = 2'b10;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = pa[i*8 +: 8];
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("mid_busy", frame_busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_tx_valid", tx_valid, 0);
        check("mid_tx_data", tx_data, 0);
        check("mid_busy_clr", frame_busy, 0);
        check("mid_overflow", overflow, 0);
        check("mid_count", frame_count, 0);
        exp_count = 0;
        h = hdr_of(2'b10);
        drive_frame(2'b10, pa, 0, h);
        wait_idle("post_rst");

        check("sb_empty", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
